// File: rtl/component_regfile_pkg.sv
// Shared constants for the component register file: record field layout,
// command opcodes, component type codes and FSM state encoding.
package component_regfile_pkg;

  // Record field layout (bit positions inside one component record)
  localparam int ID_MSB        = 2;
  localparam int ID_LSB        = 0;
  localparam int TYPE_MSB      = 5;
  localparam int TYPE_LSB      = 3;
  localparam int CURR_TEMP_MSB = 69;
  localparam int CURR_TEMP_LSB = 6;
  localparam int EXTRA_MSB     = 101;
  localparam int EXTRA_LSB     = 70;
  localparam int NAME_MSB      = 229;
  localparam int NAME_LSB      = 102;

  // Fan-specific overlay of the EXTRA field
  localparam int FAN_ON_BIT    = 101;
  localparam int FAN_SPEED_MSB = 100;
  localparam int FAN_SPEED_LSB = 99;

  typedef enum logic [1:0] {
    OP_WRITE_FIELD = 2'd0,
    OP_READ_FIELD  = 2'd1,
    OP_CLEAR_REC   = 2'd2,
    OP_RESERVED    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    TYPE_FAN       = 3'd0,
    TYPE_BOILER    = 3'd1,
    TYPE_SENSOR    = 3'd2,
    TYPE_AC_UNIT   = 3'd3,
    TYPE_CONDENSER = 3'd4
  } comp_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/component_regfile_field_mask.sv
// Turns a (msb, width) field description into a record-wide bit mask and the
// field's lsb position, flagging descriptions that fall outside the record.
module component_regfile_field_mask #(
  parameter int REC_W = 230,
  parameter int VAL_W = 32,
  parameter int MSB_W = 8,
  parameter int WID_W = 6
) (
  input  logic [MSB_W-1:0] i_msb,
  input  logic [WID_W-1:0] i_width,
  output logic [REC_W-1:0] o_mask,
  output logic [MSB_W-1:0] o_lsb,
  output logic             o_range_err
);

  // Range check, then mask bits lsb..msb; the mask stays zero on a bad range
  always_comb begin
    int msb_i;
    int wid_i;
    msb_i       = int'(i_msb);
    wid_i       = int'(i_width);
    o_range_err = (wid_i == 0) || (wid_i > VAL_W) || (msb_i >= REC_W) ||
                  (wid_i > msb_i + 1);
    o_mask      = '0;
    o_lsb       = '0;
    if (!o_range_err) begin
      o_lsb = MSB_W'(msb_i - wid_i + 1);
      for (int b = 0; b < REC_W; b++) begin
        o_mask[b] = (b <= msb_i) && (b > msb_i - wid_i);
      end
    end
  end

endmodule

// File: rtl/component_regfile.sv
// Component register file: NUM_COMP records of REC_W bits, accessed through
// field-granular commands (write / read / clear) with a valid/ready command
// channel and a valid/ready response channel.
//
// Handshake: a transfer happens on a rising CLK edge where valid && ready are
// both 1; the producer holds valid and its payload stable until that edge.
// cmd_ready is 1 only while the FSM is idle, so one command is in flight at
// a time; the response is held until rsp_ready is seen.
module component_regfile
  import component_regfile_pkg::*;
#(
  parameter int NUM_COMP = 8,
  parameter int REC_W    = 230,
  parameter int VAL_W    = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [$clog2(NUM_COMP)-1:0] cmd_id,
  input  logic [$clog2(REC_W)-1:0]    cmd_msb,
  input  logic [$clog2(VAL_W):0]      cmd_width,
  input  logic [VAL_W-1:0]            cmd_value,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [1:0]                  rsp_op,
  output logic [$clog2(NUM_COMP)-1:0] rsp_id,
  output logic [$clog2(REC_W)-1:0]    rsp_msb,
  output logic [$clog2(VAL_W):0]      rsp_width,
  output logic [VAL_W-1:0]            rsp_value,
  output logic                        rsp_err,
  input  logic [$clog2(NUM_COMP)-1:0] snap_sel,
  output logic [REC_W-1:0]            snap_rec,
  output logic [1:0]                  dbg_state
);

  localparam int ID_W  = $clog2(NUM_COMP);
  localparam int MSB_W = $clog2(REC_W);
  localparam int WID_W = $clog2(VAL_W) + 1;

  // Bits preserved by CLEAR_REC (the read-only ID field)
  localparam logic [REC_W-1:0] ID_KEEP =
    REC_W'({(ID_MSB - ID_LSB + 1){1'b1}}) << ID_LSB;

  state_e             r_state;
  op_e                r_op;
  logic [ID_W-1:0]    r_id;
  logic [MSB_W-1:0]   r_msb;
  logic [WID_W-1:0]   r_width;
  logic [VAL_W-1:0]   r_value;
  logic [REC_W-1:0]   r_recs [NUM_COMP];

  logic               r_rsp_valid;
  op_e                r_rsp_op;
  logic [ID_W-1:0]    r_rsp_id;
  logic [MSB_W-1:0]   r_rsp_msb;
  logic [WID_W-1:0]   r_rsp_width;
  logic [VAL_W-1:0]   r_rsp_value;
  logic               r_rsp_err;

  logic [REC_W-1:0]   w_mask;
  logic [MSB_W-1:0]   w_lsb;
  logic               w_range_err;
  logic [REC_W-1:0]   w_cur;
  logic [REC_W-1:0]   w_ins;
  logic [REC_W-1:0]   w_next_rec;
  logic [VAL_W-1:0]   w_rsp_value;
  logic               w_err;
  logic               w_do_update;

  component_regfile_field_mask #(
    .REC_W (REC_W),
    .VAL_W (VAL_W),
    .MSB_W (MSB_W),
    .WID_W (WID_W)
  ) u_field_mask (
    .i_msb       (r_msb),
    .i_width     (r_width),
    .o_mask      (w_mask),
    .o_lsb       (w_lsb),
    .o_range_err (w_range_err)
  );

  // Select the record addressed by the latched command
  always_comb begin
    w_cur = '0;
    for (int i = 0; i < NUM_COMP; i++) begin
      if (int'(r_id) == i) w_cur = r_recs[i];
    end
  end

  // Error decode, read-modify-write data and response value for EXEC
  always_comb begin
    w_err = (int'(r_id) >= NUM_COMP) ||
            (r_op == OP_RESERVED) ||
            ((r_op != OP_CLEAR_REC) && w_range_err) ||
            ((r_op == OP_WRITE_FIELD) && (|w_mask[ID_MSB:ID_LSB]));
    w_ins = (REC_W'(r_value) << w_lsb) & w_mask;
    w_next_rec  = w_cur;
    w_rsp_value = '0;
    case (r_op)
      OP_WRITE_FIELD: begin
        w_next_rec  = (w_cur & ~w_mask) | w_ins;
        w_rsp_value = VAL_W'(w_ins >> w_lsb);
      end
      OP_READ_FIELD:  w_rsp_value = VAL_W'((w_cur & w_mask) >> w_lsb);
      OP_CLEAR_REC:   w_next_rec  = w_cur & ID_KEEP;
      default:        w_next_rec  = w_cur;
    endcase
    if (w_err) w_rsp_value = '0;
    w_do_update = (r_state == ST_EXEC) && !w_err &&
                  ((r_op == OP_WRITE_FIELD) || (r_op == OP_CLEAR_REC));
  end

  // Record storage: reset to ID-only records, updated once per good EXEC
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_COMP; i++) r_recs[i] <= REC_W'(i);
    end else if (w_do_update) begin
      for (int i = 0; i < NUM_COMP; i++) begin
        if (int'(r_id) == i) r_recs[i] <= w_next_rec;
      end
    end
  end

  // Command FSM: IDLE accepts, EXEC updates, RESP holds until consumed
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_WRITE_FIELD;
      r_id        <= '0;
      r_msb       <= '0;
      r_width     <= '0;
      r_value     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_op    <= OP_WRITE_FIELD;
      r_rsp_id    <= '0;
      r_rsp_msb   <= '0;
      r_rsp_width <= '0;
      r_rsp_value <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op    <= op_e'(cmd_op);
            r_id    <= cmd_id;
            r_msb   <= cmd_msb;
            r_width <= cmd_width;
            r_value <= cmd_value;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_valid <= 1'b1;
          r_rsp_op    <= r_op;
          r_rsp_id    <= r_id;
          r_rsp_msb   <= r_msb;
          r_rsp_width <= r_width;
          r_rsp_value <= w_rsp_value;
          r_rsp_err   <= w_err;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Combinational snapshot of one record; out-of-range selects read zero
  always_comb begin
    snap_rec = '0;
    for (int i = 0; i < NUM_COMP; i++) begin
      if (int'(snap_sel) == i) snap_rec = r_recs[i];
    end
  end

  assign cmd_ready = (r_state == ST_IDLE) && !RST;
  assign rsp_valid = r_rsp_valid;
  assign rsp_op    = r_rsp_op;
  assign rsp_id    = r_rsp_id;
  assign rsp_msb   = r_rsp_msb;
  assign rsp_width = r_rsp_width;
  assign rsp_value = r_rsp_value;
  assign rsp_err   = r_rsp_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_component_regfile.sv
// Directed bench for component_regfile (built with 6 records so that an
// out-of-range component id can be driven on the 3-bit id port).
module tb_component_regfile;

  localparam int NC = 6;
  localparam int RW = 230;
  localparam int VW = 32;
  localparam int IW = $clog2(NC);
  localparam int MW = $clog2(RW);
  localparam int WW = $clog2(VW) + 1;

  typedef struct packed {
    logic [1:0]    op;
    logic [IW-1:0] id;
    logic [MW-1:0] msb;
    logic [WW-1:0] width;
    logic [VW-1:0] value;
  } vec_t;

  logic          CLK;
  logic          RST;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [IW-1:0] cmd_id;
  logic [MW-1:0] cmd_msb;
  logic [WW-1:0] cmd_width;
  logic [VW-1:0] cmd_value;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_op;
  logic [IW-1:0] rsp_id;
  logic [MW-1:0] rsp_msb;
  logic [WW-1:0] rsp_width;
  logic [VW-1:0] rsp_value;
  logic          rsp_err;
  logic [IW-1:0] snap_sel;
  logic [RW-1:0] snap_rec;
  logic [1:0]    dbg_state;

  int            total;
  int            bad;
  logic [VW-1:0] got_value;
  logic          got_err;
  logic [RW-1:0] exp_rec [NC];

  component_regfile #(.NUM_COMP(NC), .REC_W(RW), .VAL_W(VW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_id    (cmd_id),
    .cmd_msb   (cmd_msb),
    .cmd_width (cmd_width),
    .cmd_value (cmd_value),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_op    (rsp_op),
    .rsp_id    (rsp_id),
    .rsp_msb   (rsp_msb),
    .rsp_width (rsp_width),
    .rsp_value (rsp_value),
    .rsp_err   (rsp_err),
    .snap_sel  (snap_sel),
    .snap_rec  (snap_rec),
    .dbg_state (dbg_state)
  );

  // Clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: one full command/response transaction, entered after a negedge
  task automatic send_cmd(input logic [1:0] op, input logic [IW-1:0] id,
                          input logic [MW-1:0] msb, input logic [WW-1:0] width,
                          input logic [VW-1:0] value);
    int n;
    got_value = 'x;
    got_err   = 1'bx;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_id    = id;
    cmd_msb   = msb;
    cmd_width = width;
    cmd_value = value;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: cmd_ready=%0b required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    @(negedge CLK);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!rsp_valid) begin
      total++; bad++;
      $display("FAIL rsp_timeout: rsp_valid=%0b required 1", rsp_valid);
      return;
    end
    got_value = rsp_value;
    got_err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_id = '0; cmd_msb = '0; cmd_width = '0; cmd_value = '0;
    snap_sel = '0;
    repeat (3) @(negedge CLK);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready: got %0b want 0", cmd_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got %0b want 0", rsp_err); end
    total++; if (rsp_value !== '0) begin bad++; $display("FAIL reset_rsp_value: got %h want 0", rsp_value); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    RST = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %0b want 1", cmd_ready); end
    for (int i = 0; i < NC; i++) begin
      exp_rec[i] = RW'(i);
      snap_sel = IW'(i);
      #1;
      total++; if (snap_rec !== exp_rec[i]) begin bad++; $display("FAIL reset_rec%0d: got %h want %h", i, snap_rec, exp_rec[i]); end
    end
    snap_sel = 3'd7;
    #1;
    total++; if (snap_rec !== '0) begin bad++; $display("FAIL snap_out_of_range: got %h want 0", snap_rec); end
    @(negedge CLK);
  endtask

  task automatic test_read_id();
    send_cmd(2'd1, 3'd3, 8'd2, 6'd3, 32'd0);
    total++; if (got_err !== 1'b0) begin bad++; $display("FAIL read_id_err: got %0b want 0", got_err); end
    total++; if (got_value !== 32'd3) begin bad++; $display("FAIL read_id_value: got %h want 3", got_value); end
    snap_sel = 3'd4;
    #1;
    total++; if (snap_rec !== RW'(4)) begin bad++; $display("FAIL snap_rec4: got %h want 4", snap_rec); end
  endtask

  task automatic test_write_field();
    send_cmd(2'd0, 3'd0, 8'd100, 6'd2, 32'h2);
    exp_rec[0][100:99] = 2'b10;
    total++; if (got_err !== 1'b0) begin bad++; $display("FAIL fan_speed_err: got %0b want 0", got_err); end
    total++; if (got_value !== 32'h2) begin bad++; $display("FAIL fan_speed_wval: got %h want 2", got_value); end
    snap_sel = 3'd0;
    #1;
    total++; if (snap_rec !== exp_rec[0]) begin bad++; $display("FAIL fan_speed_rec: got %h want %h", snap_rec, exp_rec[0]); end
    send_cmd(2'd1, 3'd0, 8'd100, 6'd2, 32'd0);
    total++; if (got_value !== 32'h2) begin bad++; $display("FAIL fan_speed_read: got %h want 2", got_value); end
    // Upper value bits beyond the field width must be discarded
    send_cmd(2'd0, 3'd0, 8'd101, 6'd1, 32'hFFFF_FFFF);
    exp_rec[0][101] = 1'b1;
    total++; if (got_value !== 32'h1) begin bad++; $display("FAIL fan_on_wval: got %h want 1", got_value); end
    send_cmd(2'd1, 3'd0, 8'd101, 6'd3, 32'd0);
    total++; if (got_value !== 32'h6) begin bad++; $display("FAIL fan_bits_read: got %h want 6", got_value); end
    send_cmd(2'd0, 3'd0, 8'd5, 6'd3, 32'h3);
    exp_rec[0][5:3] = 3'b011;
    total++; if (got_err !== 1'b0) begin bad++; $display("FAIL type_err: got %0b want 0", got_err); end
    snap_sel = 3'd0;
    #1;
    total++; if (snap_rec !== exp_rec[0]) begin bad++; $display("FAIL type_rec: got %h want %h", snap_rec, exp_rec[0]); end
  endtask

  task automatic test_float_and_clear();
    send_cmd(2'd0, 3'd1, 8'd69, 6'd32, 32'h41E0_0000);
    exp_rec[1][69:38] = 32'h41E0_0000;
    total++; if (got_value !== 32'h41E0_0000) begin bad++; $display("FAIL temp_wval: got %h want 41e00000", got_value); end
    send_cmd(2'd0, 3'd1, 8'd37, 6'd32, 32'd0);
    total++; if (got_err !== 1'b0) begin bad++; $display("FAIL low_word_err: got %0b want 0", got_err); end
    send_cmd(2'd1, 3'd1, 8'd69, 6'd32, 32'd0);
    total++; if (got_value !== 32'h41E0_0000) begin bad++; $display("FAIL temp_read: got %h want 41e00000", got_value); end
    send_cmd(2'd1, 3'd1, 8'd69, 6'd4, 32'd0);
    total++; if (got_value !== 32'h4) begin bad++; $display("FAIL temp_nibble: got %h want 4", got_value); end
    snap_sel = 3'd1;
    #1;
    total++; if (snap_rec !== exp_rec[1]) begin bad++; $display("FAIL temp_rec: got %h want %h", snap_rec, exp_rec[1]); end
    // msb/width are ignored by CLEAR_REC, even when out of range
    send_cmd(2'd2, 3'd1, 8'd0, 6'd0, 32'hDEAD);
    exp_rec[1] = RW'(1);
    total++; if (got_err !== 1'b0) begin bad++; $display("FAIL clear_err: got %0b want 0", got_err); end
    total++; if (got_value !== 32'd0) begin bad++; $display("FAIL clear_value: got %h want 0", got_value); end
    snap_sel = 3'd1;
    #1;
    total++; if (snap_rec !== exp_rec[1]) begin bad++; $display("FAIL clear_rec: got %h want %h", snap_rec, exp_rec[1]); end
  endtask

  task automatic test_errors();
    vec_t vecs [9];
    vecs[0] = '{op: 2'd1, id: 3'd6, msb: 8'd2,   width: 6'd3,  value: 32'd0};
    vecs[1] = '{op: 2'd0, id: 3'd6, msb: 8'd100, width: 6'd2,  value: 32'd1};
    vecs[2] = '{op: 2'd1, id: 3'd0, msb: 8'd5,   width: 6'd0,  value: 32'd0};
    vecs[3] = '{op: 2'd0, id: 3'd0, msb: 8'd2,   width: 6'd1,  value: 32'd1};
    vecs[4] = '{op: 2'd0, id: 3'd0, msb: 8'd3,   width: 6'd2,  value: 32'd3};
    vecs[5] = '{op: 2'd0, id: 3'd0, msb: 8'd4,   width: 6'd6,  value: 32'h3F};
    vecs[6] = '{op: 2'd0, id: 3'd0, msb: 8'd230, width: 6'd1,  value: 32'd1};
    vecs[7] = '{op: 2'd0, id: 3'd0, msb: 8'd100, width: 6'd33, value: 32'hFFFF_FFFF};
    vecs[8] = '{op: 2'd3, id: 3'd0, msb: 8'd100, width: 6'd2,  value: 32'd3};
    for (int k = 0; k < 9; k++) begin
      send_cmd(vecs[k].op, vecs[k].id, vecs[k].msb, vecs[k].width, vecs[k].value);
      total++; if (got_err !== 1'b1) begin bad++; $display("FAIL err_flag[%0d]: got %0b want 1", k, got_err); end
      total++; if (got_value !== 32'd0) begin bad++; $display("FAIL err_value[%0d]: got %h want 0", k, got_value); end
      snap_sel = 3'd0;
      #1;
      total++; if (snap_rec !== exp_rec[0]) begin bad++; $display("FAIL err_rec0[%0d]: got %h want %h", k, snap_rec, exp_rec[0]); end
    end
  endtask

  task automatic test_back_to_back();
    snap_sel  = 3'd2;
    cmd_valid = 1'b1;
    cmd_op = 2'd0; cmd_id = 3'd2; cmd_msb = 8'd37; cmd_width = 6'd8; cmd_value = 32'hA5;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_idle: got %0b want 1", cmd_ready); end
    @(posedge CLK);
    @(negedge CLK);
    // Second command presented immediately; it must wait for the handshake
    cmd_op = 2'd1; cmd_value = 32'd0;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_exec_valid: got %0b want 0", rsp_valid); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_exec_ready: got %0b want 0", cmd_ready); end
    @(negedge CLK);
    exp_rec[2][37:30] = 8'hA5;
    total++; if (snap_rec !== exp_rec[2]) begin bad++; $display("FAIL bp_rec2: got %h want %h", snap_rec, exp_rec[2]); end
    for (int c = 0; c < 5; c++) begin
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %0b want 1", c, rsp_valid); end
      total++; if (rsp_value !== 32'hA5) begin bad++; $display("FAIL bp_value[%0d]: got %h want a5", c, rsp_value); end
      total++; if ({rsp_op, rsp_id, rsp_msb, rsp_width, rsp_err} !== {2'd0, 3'd2, 8'd37, 6'd8, 1'b0}) begin
        bad++; $display("FAIL bp_echo[%0d]: got op=%0d id=%0d msb=%0d w=%0d err=%0b want op=0 id=2 msb=37 w=8 err=0",
                        c, rsp_op, rsp_id, rsp_msb, rsp_width, rsp_err);
      end
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d]: got %0b want 0", c, cmd_ready); end
      @(negedge CLK);
    end
    rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_drop_valid: got %0b want 0", rsp_valid); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after: got %0b want 1", cmd_ready); end
    @(posedge CLK);
    @(negedge CLK);
    cmd_valid = 1'b0;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_exec_valid: got %0b want 0", rsp_valid); end
    @(negedge CLK);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %0b want 1", rsp_valid); end
    total++; if (rsp_value !== 32'hA5) begin bad++; $display("FAIL b2b_read: got %h want a5", rsp_value); end
    total++; if (rsp_op !== 2'd1) begin bad++; $display("FAIL b2b_op: got %0d want 1", rsp_op); end
    rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_in_resp();
    cmd_valid = 1'b1;
    cmd_op = 2'd0; cmd_id = 3'd3; cmd_msb = 8'd69; cmd_width = 6'd4; cmd_value = 32'hF;
    @(posedge CLK);
    @(negedge CLK);
    cmd_valid = 1'b0;
    @(negedge CLK);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rr_pending: got %0b want 1", rsp_valid); end
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rr_valid: got %0b want 0", rsp_valid); end
    total++; if (rsp_value !== '0) begin bad++; $display("FAIL rr_value: got %h want 0", rsp_value); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rr_ready_in_reset: got %0b want 0", cmd_ready); end
    RST = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rr_ready_after: got %0b want 1", cmd_ready); end
    for (int i = 0; i < NC; i++) begin
      exp_rec[i] = RW'(i);
      snap_sel = IW'(i);
      #1;
      total++; if (snap_rec !== exp_rec[i]) begin bad++; $display("FAIL rr_rec%0d: got %h want %h", i, snap_rec, exp_rec[i]); end
    end
    @(negedge CLK);
    send_cmd(2'd1, 3'd3, 8'd69, 6'd4, 32'd0);
    total++; if (got_value !== 32'd0) begin bad++; $display("FAIL rr_readback: got %h want 0", got_value); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_read_id();
    test_write_field();
    test_float_and_clear();
    test_errors();
    test_back_to_back();
    test_reset_in_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
